// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit definitions: FSM encoding, reset PC, decoder opcodes.
// No logic; imported by the fetch unit and its next-PC helper.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection: jump > taken beq > sequential, all modulo 2^32.
// Purely combinational, zero latency, no flow control.
module ifu_npc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ins,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_npc
);

  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_unused_opc;

  // Opcode field is the decoder's business; only the immediates matter here.
  assign w_unused_opc = &{1'b0, i_ins[31:26]};

  assign o_pc_plus4 = i_pc + 32'd4;
  assign w_br_off   = {{14{i_ins[15]}}, i_ins[15:0], 2'b00};
  assign w_br_tgt   = o_pc_plus4 + w_br_off;
  assign w_j_tgt    = {o_pc_plus4[31:28], i_ins[25:0], 2'b00};

  always_comb begin
    o_npc = o_pc_plus4;
    if (i_jump) begin
      o_npc = w_j_tgt;
    end else if (i_branch && i_zero) begin
      o_npc = w_br_tgt;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Multi-cycle fetch FSM: FETCH (req until gnt) -> WAIT (rvalid) -> EXEC (hold until ack).
// Min 3 cycles per instruction; stalls on gnt low, missing rvalid, or no ack.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ack,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ins;
  logic         r_ins_valid;
  logic         r_imem_req;
  logic [31:0]  w_npc;
  logic [31:0]  w_pc_plus4;

  ifu_npc u_npc (
    .i_pc       (r_pc),
    .i_ins      (r_ins),
    .i_branch   (branch),
    .i_jump     (jump),
    .i_zero     (zero),
    .o_pc_plus4 (w_pc_plus4),
    .o_npc      (w_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC_ALIGNED;
      r_ins       <= 32'd0;
      r_ins_valid <= 1'b0;
      r_imem_req  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_imem_req <= 1'b1;
          if (r_imem_req && imem_gnt) begin
            r_imem_req <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_ins       <= imem_rdata;
            r_ins_valid <= 1'b1;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Re-arm the request here so the next FETCH issues without a bubble.
          if (ins_ack) begin
            r_pc        <= w_npc;
            r_ins_valid <= 1'b0;
            r_imem_req  <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign ins       = r_ins;
  assign ins_valid = r_ins_valid;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;

endmodule
